// File: rtl/reaction_timer.sv
// Reaction-time meter: random wait after a start press, then a BCD millisecond count
// until the stop press, with false-start detection and 9999 ms saturation.
module reaction_timer #(
  parameter int TICKS_PER_MS = 100000,
  parameter int MIN_DELAY_MS = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] rd3,
  output logic [3:0] rd2,
  output logic [3:0] rd1,
  output logic [3:0] rd0,
  output logic       go_led,
  output logic       early,
  output logic       done,
  output logic [2:0] state_dbg
);

  localparam int TW = $clog2(TICKS_PER_MS);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICKS_PER_MS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_GO    = 3'd2,
    S_DONE  = 3'd3,
    S_EARLY = 3'd4
  } state_t;

  state_t        state;
  logic          start_s1, start_s2, start_s3, start_p;
  logic          stop_s1, stop_s2, stop_s3, stop_p;
  logic [15:0]   lfsr;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [12:0]   wait_cnt;
  logic [12:0]   wait_load;
  logic [3:0]    d3, d2, d1, d0;
  logic          at_max;

  // Two synchronizer flops, one history flop, and a registered rising-edge pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      start_s1 <= 1'b0;
      start_s2 <= 1'b0;
      start_s3 <= 1'b0;
      start_p  <= 1'b0;
      stop_s1  <= 1'b0;
      stop_s2  <= 1'b0;
      stop_s3  <= 1'b0;
      stop_p   <= 1'b0;
    end else begin
      start_s1 <= start;
      start_s2 <= start_s1;
      start_s3 <= start_s2;
      start_p  <= start_s2 & ~start_s3;
      stop_s1  <= stop;
      stop_s2  <= stop_s1;
      stop_s3  <= stop_s2;
      stop_p   <= stop_s2 & ~stop_s3;
    end
  end

  // Right-shifting Fibonacci form; bit 0 is tap 16, so taps 16,14,13,11 are bits 0,2,3,5.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= 16'hACE1;
    else      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  end

  assign tick      = (tick_cnt == TICK_MAX);
  assign wait_load = 13'(MIN_DELAY_MS) + {1'b0, lfsr[11:0]};
  assign at_max    = (d3 == 4'd9) && (d2 == 4'd9) && (d1 == 4'd9) && (d0 == 4'd9);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      wait_cnt <= '0;
      d3       <= 4'd0;
      d2       <= 4'd0;
      d1       <= 4'd0;
      d0       <= 4'd0;
      go_led   <= 1'b0;
      early    <= 1'b0;
      done     <= 1'b0;
    end else begin
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      case (state)
        S_IDLE, S_DONE, S_EARLY: begin
          if (start_p) begin
            state    <= S_WAIT;
            tick_cnt <= '0;
            wait_cnt <= wait_load;
            d3       <= 4'd0;
            d2       <= 4'd0;
            d1       <= 4'd0;
            d0       <= 4'd0;
            go_led   <= 1'b0;
            early    <= 1'b0;
            done     <= 1'b0;
          end
        end
        S_WAIT: begin
          if (stop_p) begin
            state <= S_EARLY;
            early <= 1'b1;
          end else if (tick) begin
            wait_cnt <= wait_cnt - 13'd1;
            if (wait_cnt == 13'd1) begin
              state    <= S_GO;
              tick_cnt <= '0;
              go_led   <= 1'b1;
            end
          end
        end
        S_GO: begin
          if (stop_p || (tick && at_max)) begin
            state  <= S_DONE;
            go_led <= 1'b0;
            done   <= 1'b1;
          end else if (tick) begin
            // Cascaded decade increment; at_max above keeps d3 from passing 9.
            if (d0 != 4'd9) d0 <= d0 + 4'd1;
            else begin
              d0 <= 4'd0;
              if (d1 != 4'd9) d1 <= d1 + 4'd1;
              else begin
                d1 <= 4'd0;
                if (d2 != 4'd9) d2 <= d2 + 4'd1;
                else begin
                  d2 <= 4'd0;
                  d3 <= d3 + 4'd1;
                end
              end
            end
          end
        end
        default: begin
          state  <= S_IDLE;
          go_led <= 1'b0;
          early  <= 1'b0;
          done   <= 1'b0;
        end
      endcase
    end
  end

  assign {rd3, rd2, rd1, rd0} = (state == S_EARLY) ? 16'h9999 : {d3, d2, d1, d0};
  assign state_dbg = state;

endmodule
